// File: rtl/fnd_pkg.sv
// fnd_pkg: shared types and constants for the FND scan path.
// Slot encoding, anode patterns and per-slot nibble helpers.
package fnd_pkg;

    typedef enum logic [1:0] {
        SLOT_D1    = 2'd0,
        SLOT_D10   = 2'd1,
        SLOT_D100  = 2'd2,
        SLOT_D1000 = 2'd3
    } slot_e;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_e;

    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_D1    = 4'b1110;
    localparam logic [3:0] AN_D10   = 4'b1101;
    localparam logic [3:0] AN_D100  = 4'b1011;
    localparam logic [3:0] AN_D1000 = 4'b0111;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] slot_anode(slot_e s);
        logic [3:0] an;
        an = AN_OFF;
        unique case (s)
            SLOT_D1:    an = AN_D1;
            SLOT_D10:   an = AN_D10;
            SLOT_D100:  an = AN_D100;
            SLOT_D1000: an = AN_D1000;
        endcase
        return an;
    endfunction

    function automatic logic [3:0] slot_nibble(logic [15:0] v, slot_e s);
        return v[int'(s)*4 +: 4];
    endfunction

    // True when this slot's nibble and every higher-order nibble are zero.
    function automatic logic upper_zero(logic [15:0] v, slot_e s);
        logic z;
        z = 1'b0;
        unique case (s)
            SLOT_D1:    z = (v == 16'h0);
            SLOT_D10:   z = (v[15:4] == 12'h0);
            SLOT_D100:  z = (v[15:8] == 8'h0);
            SLOT_D1000: z = (v[15:12] == 4'h0);
        endcase
        return z;
    endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// fnd_tick_gen: free-running divider producing a 1-cycle clock enable.
// The pulse is high while the counter sits at DIV-1.
module fnd_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign o_tick = (cnt == LAST);

    // Count 0..DIV-1 and wrap on the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fnd_scan_scheduler.sv
// fnd_scan_scheduler: 4-digit FND multiplex scan with frame-aligned
// data commit, leading-zero / invalid-BCD blanking and blink.
module fnd_scan_scheduler
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV   = 100_000,
    parameter int BLINK_HALF = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_bcd,
    input  logic        i_lz_blank,
    input  logic        i_blink_en,
    output logic [3:0]  o_fnd_digit,
    output logic [3:0]  o_bcd,
    output logic        o_blank,
    output logic        o_frame_start
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic          tick;
    logic          boundary;
    logic          accept;
    slot_e         slot;
    slot_e         slot_nx;
    logic          pending;
    logic [15:0]   shadow;
    logic [15:0]   disp;
    logic [15:0]   disp_nx;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nx;
    phase_e        phase;
    phase_e        phase_nx;
    logic [3:0]    nib_nx;
    logic          blank_nx;

    fnd_tick_gen #(
        .DIV(SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (tick)
    );

    assign o_ready  = !pending;
    assign accept   = i_valid && o_ready;
    assign boundary = tick && (slot == SLOT_D1000);

    // Next-slot view: committed data, blink phase and blank decision.
    always_comb begin
        slot_nx      = slot_e'(slot + 2'd1);
        disp_nx      = disp;
        blink_cnt_nx = blink_cnt;
        phase_nx     = phase;
        if (boundary && pending) begin
            disp_nx = shadow;
        end
        if (boundary) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                phase_nx     = (phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt_nx = blink_cnt + BW'(1);
            end
        end
        nib_nx   = slot_nibble(disp_nx, slot_nx);
        blank_nx = (i_blink_en && (phase_nx == PH_OFF))
                || (nib_nx > BCD_MAX)
                || (i_lz_blank && (slot_nx != SLOT_D1)
                    && upper_zero(disp_nx, slot_nx));
    end

    // Scan position, blink state and the shadow/display data pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot      <= SLOT_D1;
            blink_cnt <= '0;
            phase     <= PH_ON;
            disp      <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
        end else begin
            if (tick) begin
                slot      <= slot_nx;
                blink_cnt <= blink_cnt_nx;
                phase     <= phase_nx;
                disp      <= disp_nx;
            end
            if (accept) begin
                shadow  <= i_bcd;
                pending <= 1'b1;
            end else if (boundary && pending) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered scan outputs, refreshed only on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_fnd_digit   <= AN_OFF;
            o_bcd         <= 4'h0;
            o_blank       <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= tick && (slot_nx == SLOT_D1);
            if (tick) begin
                o_fnd_digit <= slot_anode(slot_nx);
                o_bcd       <= nib_nx;
                o_blank     <= blank_nx;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// tb_fnd_scan_scheduler: scoreboard bench for the FND scan scheduler.
// Expected slot views are queued with the stimulus and popped per slot.
module tb_fnd_scan_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_bcd;
    logic        i_lz_blank;
    logic        i_blink_en;
    logic [3:0]  o_fnd_digit;
    logic [3:0]  o_bcd;
    logic        o_blank;
    logic        o_frame_start;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb[$];
    logic [3:0] last_an = 4'b1111;

    always #5 clk = ~clk;

    fnd_scan_scheduler #(
        .SCAN_DIV   (4),
        .BLINK_HALF (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_bcd         (i_bcd),
        .i_lz_blank    (i_lz_blank),
        .i_blink_en    (i_blink_en),
        .o_fnd_digit   (o_fnd_digit),
        .o_bcd         (o_bcd),
        .o_blank       (o_blank),
        .o_frame_start (o_frame_start)
    );

    function automatic logic [9:0] got_v();
        return {o_fnd_digit, o_bcd, o_blank, o_frame_start};
    endfunction

    function automatic logic [9:0] mk(int s, logic [3:0] b,
                                      logic bl, logic fs);
        logic [3:0] an;
        case (s)
            0:       an = 4'b1110;
            1:       an = 4'b1101;
            2:       an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return {an, b, bl, fs};
    endfunction

    // Called at a negedge; returns at the negedge where a new slot shows.
    task automatic wait_slot(output bit to, output int dt);
        to = 1'b1;
        dt = 0;
        for (int i = 0; i < 64; i++) begin
            if (o_fnd_digit !== last_an) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            dt++;
        end
        last_an = o_fnd_digit;
    endtask

    task automatic test_reset();
        i_valid    = 1'b0;
        i_bcd      = 16'h0;
        i_lz_blank = 1'b0;
        i_blink_en = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_fnd_digit !== 4'b1111) begin
            failures++;
            $display("FAIL rst_digit got=%b exp=1111", o_fnd_digit);
        end
        checks++;
        if (o_bcd !== 4'h0) begin
            failures++;
            $display("FAIL rst_bcd got=%h exp=0", o_bcd);
        end
        checks++;
        if (o_blank !== 1'b1) begin
            failures++;
            $display("FAIL rst_blank got=%b exp=1", o_blank);
        end
        checks++;
        if (o_frame_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_fs got=%b exp=0", o_frame_start);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=1", o_ready);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_fnd_digit !== 4'b1111 || o_blank !== 1'b1) begin
                failures++;
                $display("FAIL predark%0d got=%b/%b exp=1111/1",
                         k, o_fnd_digit, o_blank);
            end
        end
        last_an = 4'b1111;
    endtask

    task automatic test_scan();
        bit to;
        int dt;
        logic [9:0] e;
        for (int k = 0; k < 8; k++)
            sb.push_back(mk((k + 1) % 4, 4'h0, 1'b0, ((k + 1) % 4) == 0));
        for (int k = 0; k < 8; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL scan%0d got=%h exp=%h to=%0d",
                         k, got_v(), e, to);
            end
            if (k > 0) begin
                checks++;
                if (dt != 4) begin
                    failures++;
                    $display("FAIL scan_period got=%0d exp=4", dt);
                end
            end
        end
    endtask

    task automatic test_load();
        bit to;
        int dt;
        logic [9:0] e;
        logic [6:0] rdy;
        sb.push_back(mk(1, 4'h0, 1'b0, 1'b0));
        wait_slot(to, dt);
        e = sb.pop_front();
        checks++;
        if (to || got_v() !== e) begin
            failures++;
            $display("FAIL load_pre got=%h exp=%h", got_v(), e);
        end
        i_valid = 1'b1;
        i_bcd   = 16'h1234;
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL load_ready_drop got=%b exp=0", o_ready);
        end
        sb.push_back(mk(2, 4'h0, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h0, 1'b0, 1'b0));
        sb.push_back(mk(0, 4'h4, 1'b0, 1'b1));
        sb.push_back(mk(1, 4'h3, 1'b0, 1'b0));
        sb.push_back(mk(2, 4'h2, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h1, 1'b0, 1'b0));
        rdy = 7'b1111100;
        for (int k = 0; k < 6; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL load%0d got=%h exp=%h", k, got_v(), e);
            end
            checks++;
            if (o_ready !== rdy[k]) begin
                failures++;
                $display("FAIL load_ready%0d got=%b exp=%b",
                         k, o_ready, rdy[k]);
            end
        end
    endtask

    task automatic test_ignore();
        bit to;
        int dt;
        logic [9:0] e;
        sb.push_back(mk(0, 4'h4, 1'b0, 1'b1));
        wait_slot(to, dt);
        e = sb.pop_front();
        checks++;
        if (to || got_v() !== e) begin
            failures++;
            $display("FAIL ign_pre got=%h exp=%h", got_v(), e);
        end
        i_valid = 1'b1;
        i_bcd   = 16'h9876;
        @(negedge clk);
        i_bcd   = 16'h5678;
        @(negedge clk);
        i_valid = 1'b0;
        sb.push_back(mk(1, 4'h3, 1'b0, 1'b0));
        sb.push_back(mk(2, 4'h2, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h1, 1'b0, 1'b0));
        sb.push_back(mk(0, 4'h6, 1'b0, 1'b1));
        sb.push_back(mk(1, 4'h7, 1'b0, 1'b0));
        sb.push_back(mk(2, 4'h8, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h9, 1'b0, 1'b0));
        sb.push_back(mk(0, 4'h6, 1'b0, 1'b1));
        for (int k = 0; k < 8; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL ign%0d got=%h exp=%h", k, got_v(), e);
            end
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL ign_ready got=%b exp=1", o_ready);
        end
    endtask

    task automatic test_boundary_accept();
        bit to;
        int dt;
        logic [9:0] e;
        sb.push_back(mk(1, 4'h7, 1'b0, 1'b0));
        sb.push_back(mk(2, 4'h8, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h9, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL bnd_pre%0d got=%h exp=%h", k, got_v(), e);
            end
        end
        repeat (3) @(negedge clk);
        i_valid = 1'b1;
        i_bcd   = 16'h2468;
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL bnd_ready got=%b exp=0", o_ready);
        end
        sb.push_back(mk(0, 4'h6, 1'b0, 1'b1));
        sb.push_back(mk(1, 4'h7, 1'b0, 1'b0));
        sb.push_back(mk(2, 4'h8, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h9, 1'b0, 1'b0));
        sb.push_back(mk(0, 4'h8, 1'b0, 1'b1));
        sb.push_back(mk(1, 4'h6, 1'b0, 1'b0));
        sb.push_back(mk(2, 4'h4, 1'b0, 1'b0));
        sb.push_back(mk(3, 4'h2, 1'b0, 1'b0));
        for (int k = 0; k < 8; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL bnd%0d got=%h exp=%h", k, got_v(), e);
            end
        end
    endtask

    task automatic test_lz_invalid();
        bit to;
        bit synced;
        int dt;
        logic [9:0] e;
        logic [15:0] vals[4];
        logic [3:0] blk[4];
        logic [15:0] v;
        vals[0] = 16'h0042; blk[0] = 4'b1100;
        vals[1] = 16'h0000; blk[1] = 4'b1110;
        vals[2] = 16'h0102; blk[2] = 4'b1000;
        vals[3] = 16'hA00A; blk[3] = 4'b1001;
        i_lz_blank = 1'b1;
        for (int t = 0; t < 4; t++) begin
            v = vals[t];
            for (int s = 0; s < 4; s++)
                sb.push_back(mk(s, v[4*s +: 4], blk[t][s], s == 0));
            i_valid = 1'b1;
            i_bcd   = v;
            @(negedge clk);
            i_valid = 1'b0;
            synced = 1'b0;
            for (int n = 0; n < 12 && !synced; n++) begin
                wait_slot(to, dt);
                if (o_frame_start && o_ready) synced = 1'b1;
            end
            for (int s = 0; s < 4; s++) begin
                if (s > 0) wait_slot(to, dt);
                e = sb.pop_front();
                checks++;
                if (!synced || to || got_v() !== e) begin
                    failures++;
                    $display("FAIL lz%0d_s%0d got=%h exp=%h",
                             t, s, got_v(), e);
                end
            end
        end
        i_lz_blank = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bit to;
        int dt;
        logic [9:0] e;
        wait_slot(to, dt);
        wait_slot(to, dt);
        i_valid = 1'b1;
        i_bcd   = 16'h7777;
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_pend got=%b exp=0", o_ready);
        end
        wait_slot(to, dt);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (o_fnd_digit !== 4'b1111) begin
            failures++;
            $display("FAIL rmid_digit got=%b exp=1111", o_fnd_digit);
        end
        checks++;
        if (o_blank !== 1'b1) begin
            failures++;
            $display("FAIL rmid_blank got=%b exp=1", o_blank);
        end
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_ready got=%b exp=1", o_ready);
        end
        last_an = 4'b1111;
        for (int k = 0; k < 8; k++)
            sb.push_back(mk((k + 1) % 4, 4'h0, 1'b0, ((k + 1) % 4) == 0));
        for (int k = 0; k < 8; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL rmid%0d got=%h exp=%h", k, got_v(), e);
            end
        end
    endtask

    task automatic test_blink();
        bit to;
        bit dark;
        int dt;
        int f;
        logic [9:0] e;
        i_blink_en = 1'b1;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        last_an = 4'b1111;
        for (int k = 0; k < 28; k++) begin
            f    = (k + 1) / 4;
            dark = (k < 25) && (f == 2 || f == 3 || f == 6);
            sb.push_back(mk((k + 1) % 4, 4'h0, dark, ((k + 1) % 4) == 0));
        end
        for (int k = 0; k < 28; k++) begin
            wait_slot(to, dt);
            e = sb.pop_front();
            checks++;
            if (to || got_v() !== e) begin
                failures++;
                $display("FAIL blink%0d got=%h exp=%h", k, got_v(), e);
            end
            if (k == 24) i_blink_en = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_ignore();
        test_boundary_accept();
        test_lz_invalid();
        test_reset_midframe();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
